// File: rtl/alien_pkg.sv
// alien_pkg: register offsets, CTRL bit indices and direction enum shared by the alien move scheduler
package alien_pkg;
  localparam logic [1:0] ADDR_POS    = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_PERIOD = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;
  localparam int CTRL_RUN   = 0;
  localparam int CTRL_IRQEN = 1;
  localparam int CTRL_STEP  = 2;
  typedef enum logic {DIR_RIGHT = 1'b0, DIR_LEFT = 1'b1} dir_e;
endpackage

// File: rtl/alien_tick_timer.sv
// alien_tick_timer: period counter (clk, reset_n, run, clr, step, period in; tick out) firing when count reaches period-1 or one cycle after a step
module alien_tick_timer #(
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                run,
  input  logic                clr,
  input  logic                step,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick
);
  logic [PERIOD_W-1:0] cnt;
  logic                step_q;
  logic                hit;
  assign hit  = ({1'b0, cnt} + (PERIOD_W+1)'(1)) >= {1'b0, period};
  assign tick = step_q | (run & hit);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt    <= '0;
      step_q <= 1'b0;
    end else begin
      step_q <= step;
      cnt    <= (!run || clr || tick) ? '0 : cnt + PERIOD_W'(1);
    end
endmodule

// File: rtl/alien_move_scheduler.sv
// alien_move_scheduler: bouncing alien column sequencer with Avalon-MM regs (POS/CTRL/PERIOD/STATUS), irq, alien_x/alien_dir outputs
module alien_move_scheduler
  import alien_pkg::*;
#(
  parameter int POS_W          = 3,
  parameter int PERIOD_W       = 24,
  parameter int DEFAULT_PERIOD = 5000000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  output logic [POS_W-1:0] alien_x,
  output logic             alien_dir
);
  localparam logic [POS_W-1:0] MAX_POS = '1;
  logic                run, irq_en, pending, tick;
  logic                wr_ctrl, wr_period, wr_status, step_req, run_start, bounce;
  logic [PERIOD_W-1:0] period;
  logic [31:0]         rd_nx;
  logic [POS_W-1:0]    pos_nx;
  dir_e                state, state_nx;
  logic                unused_bits;
  assign unused_bits = ^{read, writedata[31:PERIOD_W]};
  assign wr_ctrl   = write && address == ADDR_CTRL;
  assign wr_period = write && address == ADDR_PERIOD;
  assign wr_status = write && address == ADDR_STATUS;
  assign step_req  = wr_ctrl & writedata[CTRL_STEP] & ~run & ~writedata[CTRL_RUN];
  assign run_start = wr_ctrl & writedata[CTRL_RUN] & ~run;
  alien_tick_timer #(.PERIOD_W(PERIOD_W)) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .run    (run),
    .clr    (wr_period | run_start),
    .step   (step_req),
    .period (period),
    .tick   (tick)
  );
  always_comb
    rd_nx = address == ADDR_POS  ? 32'({state, alien_x}) :
            address == ADDR_CTRL ? 32'({irq_en, run}) :
            address == ADDR_PERIOD ? 32'(period) : 32'(pending);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      run      <= 1'b0;
      irq_en   <= 1'b0;
      period   <= PERIOD_W'(DEFAULT_PERIOD);
      pending  <= 1'b0;
      irq      <= 1'b0;
      readdata <= '0;
    end else begin
      run      <= wr_ctrl ? writedata[CTRL_RUN] : run;
      irq_en   <= wr_ctrl ? writedata[CTRL_IRQEN] : irq_en;
      period   <= wr_period ? writedata[PERIOD_W-1:0] : period;
      pending  <= tick | (pending & ~(wr_status & writedata[0]));
      irq      <= pending & irq_en;
      readdata <= rd_nx;
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state   <= DIR_RIGHT;
      alien_x <= '0;
    end else begin
      state   <= state_nx;
      alien_x <= pos_nx;
    end
  // after a bounce the new direction is also the direction of this tick's step
  always_comb begin
    bounce   = state == DIR_RIGHT ? alien_x == MAX_POS : alien_x == '0;
    state_nx = (tick && bounce) ? (state == DIR_RIGHT ? DIR_LEFT : DIR_RIGHT) : state;
    pos_nx   = !tick ? alien_x : state_nx == DIR_RIGHT ? alien_x + POS_W'(1) : alien_x - POS_W'(1);
  end
  always_comb alien_dir = state;
endmodule

// File: tb/tb_alien_move_scheduler.sv
// tb_alien_move_scheduler: randomized and directed self-check against a triangle-wave reference model
module tb_alien_move_scheduler;
  localparam int MAXC = 7;
  localparam int DEF_P = 5000000;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        irq;
  logic [2:0]  alien_x;
  logic        alien_dir;
  int checks = 0;
  int failures = 0;
  bit m_run, m_irqen, m_pend, m_irq, m_step;
  int unsigned m_period, m_el, m_n;
  logic [31:0] m_rd;
  alien_move_scheduler dut (
    .clk(clk), .reset_n(reset_n), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .irq(irq), .alien_x(alien_x), .alien_dir(alien_dir)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic int unsigned tri_pos(input int unsigned n);
    int unsigned p;
    p = n % (2 * MAXC);
    return p <= MAXC ? p : 2 * MAXC - p;
  endfunction
  function automatic bit tri_dir(input int unsigned n);
    int unsigned p;
    p = n % (2 * MAXC);
    return n > 0 && (p == 0 || p > MAXC);
  endfunction
  task automatic cyc();
    bit tick, wc, wp, ws, n_step, n_irq, n_pend;
    int unsigned per, n_el;
    logic [31:0] n_rd;
    per  = m_period == 0 ? 1 : m_period;
    tick = m_step || (m_run && m_el + 1 >= per);
    wc = write && address == 2'd1;
    wp = write && address == 2'd2;
    ws = write && address == 2'd3;
    n_rd = address == 2'd0 ? ((32'(tri_dir(m_n)) << 3) | 32'(tri_pos(m_n))) :
           address == 2'd1 ? {30'b0, m_irqen, m_run} :
           address == 2'd2 ? 32'(m_period) : {31'b0, m_pend};
    n_irq  = m_pend & m_irqen;
    n_pend = tick | (m_pend & !(ws && writedata[0]));
    n_el   = (!m_run || tick || wp) ? 0 : m_el + 1;
    n_step = wc && writedata[2] && !m_run && !writedata[0];
    @(posedge clk);
    if (wc) begin
      m_run   = writedata[0];
      m_irqen = writedata[1];
    end
    if (wp) m_period = writedata[23:0];
    m_step = n_step;
    m_el   = n_el;
    m_irq  = n_irq;
    m_pend = n_pend;
    m_rd   = n_rd;
    m_n    = m_n + (tick ? 1 : 0);
    #1;
    chk("alien_x", 32'(alien_x), 32'(tri_pos(m_n)));
    chk("alien_dir", 32'(alien_dir), 32'(tri_dir(m_n)));
    chk("irq", 32'(irq), 32'(m_irq));
    chk("readdata", readdata, m_rd);
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; write = 1'b1; writedata = d;
    cyc();
    write = 1'b0;
  endtask
  task automatic rdchk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    address = a; read = 1'b1;
    cyc();
    read = 1'b0;
    chk(tag, readdata, exp);
  endtask
  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_alien_x", 32'(alien_x), 0);
    chk("rst_alien_dir", 32'(alien_dir), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_readdata", readdata, 0);
    m_run = 0; m_irqen = 0; m_pend = 0; m_irq = 0; m_step = 0;
    m_period = DEF_P; m_el = 0; m_n = 0; m_rd = '0;
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask
  initial begin
    int exp_x [16] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};
    int exp_d [16] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 0, 0};
    int unsigned n0;
    logic [31:0] d;
    do_reset();
    rdchk("reset_pos", 2'd0, 0);
    rdchk("reset_ctrl", 2'd1, 0);
    rdchk("reset_period", 2'd2, DEF_P);
    rdchk("reset_status", 2'd3, 0);
    chk("reset_irq", 32'(irq), 0);
    wr(2'd2, 4);
    wr(2'd1, 1);
    repeat (3) cyc();
    chk("p4_before_first", 32'(alien_x), 0);
    cyc();
    chk("p4_first_step", 32'(alien_x), 1);
    repeat (3) cyc();
    chk("p4_hold", 32'(alien_x), 1);
    cyc();
    chk("p4_second_step", 32'(alien_x), 2);
    do_reset();
    wr(2'd2, 1);
    wr(2'd1, 1);
    for (int i = 0; i < 16; i++) begin
      cyc();
      chk($sformatf("seq_x%0d", i), 32'(alien_x), 32'(exp_x[i]));
      chk($sformatf("seq_dir%0d", i), 32'(alien_dir), 32'(exp_d[i]));
    end
    wr(2'd1, 0);
    wr(2'd2, 3);
    wr(2'd1, 3);
    repeat (5) cyc();
    chk("irq_set", 32'(irq), 1);
    wr(2'd1, 2);
    wr(2'd3, 0);
    rdchk("status_w0_noeffect", 2'd3, 1);
    wr(2'd3, 1);
    cyc();
    chk("irq_cleared", 32'(irq), 0);
    wr(2'd2, 1);
    wr(2'd1, 3);
    wr(2'd3, 1);
    rdchk("clear_vs_tick", 2'd3, 1);
    wr(2'd1, 0);
    n0 = m_n;
    for (int i = 0; i < 3; i++) begin
      wr(2'd1, 4);
      cyc();
    end
    chk("step_three", 32'(alien_x), 32'(tri_pos(n0 + 3)));
    rdchk("step_reads_zero", 2'd1, 0);
    wr(2'd2, 1000);
    wr(2'd1, 1);
    n0 = m_n;
    wr(2'd1, 5);
    repeat (3) cyc();
    chk("step_ignored_run", 32'(alien_x), 32'(tri_pos(n0)));
    wr(2'd2, 100);
    wr(2'd1, 1);
    repeat (30) cyc();
    do_reset();
    rdchk("post_reset_period", 2'd2, DEF_P);
    repeat (10) cyc();
    chk("post_reset_no_tick", 32'(alien_x), 0);
    for (int i = 0; i < 3000; i++) begin
      address = 2'($urandom_range(0, 3));
      read = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 3) begin
        d = $urandom;
        if (address == 2'd1) begin
          d[0] = ($urandom_range(0, 3) != 0);
          if (d[2] && m_run) d[0] = 1'b1;
        end
        if (address == 2'd2) d = (d & 32'hFF00_0000) | 32'($urandom_range(0, 6));
        wr(address, d);
      end else cyc();
      read = 1'b0;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alien_move_scheduler.md
Name: alien_move_scheduler

Overview:
- Sequences the alien's horizontal movement and drives the 3-bit alien X position input port read by the Nios II CPU.
- A programmable tick timer steps the position one column per tick, bouncing between column 0 and column 2^POS_W-1.
- Exposes a small Avalon-MM slave for run control, step period, position readback and update interrupt with CPU acknowledge.
- Sits between the system clock domain and the existing alien X position input PIO, inside the Nios system.

Parameters:
- POS_W, 3, width of the column position; column range 0..2^POS_W-1.
- PERIOD_W, 24, width of the tick period register.
- DEFAULT_PERIOD, 5000000, reset value of the period register in clk cycles (0.1 s at 50 MHz).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- address  in  2  Avalon word address
- read  in  1  Avalon read strobe
- write  in  1  Avalon write strobe
- writedata  in  32  Avalon write data
- readdata  out  32  Avalon read data, registered
- irq  out  1  level interrupt: update pending AND irq_en
- alien_x  out  POS_W  current column; feeds the position PIO in_port
- alien_dir  out  1  0 = moving right (increasing), 1 = moving left

Behaviour:
- Reset: reset_n is asynchronous and active-low; clock is clk. On reset: readdata=0, irq=0, alien_x=0, alien_dir=0, run=0, irq_en=0, pending=0, period=DEFAULT_PERIOD, tick counter=0.
- Register map:
  - 0 POS (RO): {dir at bit POS_W, pos at bits POS_W-1..0}; upper bits 0.
  - 1 CTRL (RW): bit0 run, bit1 irq_en. Bit2 is write-only step and reads 0.
  - 2 PERIOD (RW): bits PERIOD_W-1..0.
  - 3 STATUS: bit0 pending. Writing 1 to bit0 clears it; writing 0 has no effect.
- Reads: readdata is updated every cycle from the addressed register, with a 1-cycle latency and no wait states. Read has no side effects.
- Tick counter:
  - When run=1, the counter increments each cycle.
  - When counter >= period-1, a tick pulses and the counter returns to 0.
  - Period values 0 and 1 both tick every cycle.
  - When run=0, the counter holds at 0.
- Writes to PERIOD or CTRL.run:
  - Any write to PERIOD clears the counter the same cycle, even while running.
  - Writing run 0->1 starts the count from 0.
- Step: writing CTRL with bit2=1 while run=0 (either the current run or the run being written) produces exactly one tick on the next cycle. A step write with run=1 is ignored.
- FSM (states RIGHT, LEFT). On each tick:
  - RIGHT, pos < max: pos+1.
  - RIGHT, pos = max: pos-1, go LEFT.
  - LEFT, pos > 0: pos-1.
  - LEFT, pos = 0: pos+1, go RIGHT.
  - No dwell at the ends: the bounce happens in the same tick.
  - alien_dir reflects the FSM state.
- Pending flag:
  - Set on every tick.
  - If a tick and a STATUS clear-write occur in the same cycle, set wins.
  - irq is registered and follows pending AND irq_en one cycle later.
- Latency and ordering:
  - alien_x/alien_dir change in the cycle after the tick condition.
  - The POS read reflects the new value one cycle after that.
- Write outside the documented bits: ignored. Simultaneous read and write to the same register returns the pre-write value.
- Reset mid-movement: immediate return to all reset values, with no partial tick.

Decomposition:
- Shared package alien_pkg contains:
  - register offsets (ADDR_POS=0, ADDR_CTRL=1, ADDR_PERIOD=2, ADDR_STATUS=3);
  - CTRL bit indices (CTRL_RUN=0, CTRL_IRQEN=1, CTRL_STEP=2);
  - the direction enum (DIR_RIGHT=0, DIR_LEFT=1).
- One sub-module, alien_tick_timer: the period counter with run, clear and single-step inputs and a tick output.
- Register file, FSM and irq logic stay in the top module.

Test Plan:
- Reset then read all 4 addresses -> POS=0, CTRL=0, PERIOD=5000000, STATUS=0; irq=0, alien_x=0.
- PERIOD=4, CTRL=1 -> alien_x steps 0,1,2 with exactly 4 cycles between changes; the first change is 4 cycles after run is set.
- PERIOD=1 and run for 16 ticks -> alien_x sequence 1,2,3,4,5,6,7,6,5,4,3,2,1,0,1,2; alien_dir goes to 1 on the 7->6 step and to 0 on the 0->1 step.
- irq_en=1, wait for a tick -> irq=1. Write STATUS=1 -> irq=0 the next cycle. Force the clear-write onto a tick cycle -> pending stays 1.
- run=0, write CTRL=4 three times -> alien_x advances exactly 3 columns. With run=1 a CTRL step write gives no extra tick.
- While running with PERIOD=100, assert reset_n low mid-count -> all outputs 0 asynchronously. After release, PERIOD reads 5000000 and no tick occurs while run=0.
